v_lane_sync_fifo: RTL and testbench

Parametrised synchronous FIFO that replaces the fixed 512×32 load and store FIFOs of a vector lane. The lane instantiates it twice: load path (memory → VRF) and store path (VRF → memory). Its status outputs (empty/full, almost flags, read/write counts, read/write errors) keep the existing lane semantics. New features: configurable width and depth, configurable almost thresholds, first-word-fall-through (FWFT) mode, an occupancy output, and a synchronous flush.

---
 rtl/v_lane_sync_fifo_pkg.sv | 38 +++
 rtl/v_lane_fifo_mem.sv | 45 ++++
 rtl/v_lane_sync_fifo.sv | 124 ++++++++++++
 tb/tb_v_lane_sync_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/v_lane_sync_fifo_pkg.sv
// v_lane_sync_fifo_pkg
//   Shared constants, status-flag type and flag helper for the vector-lane
//   load/store FIFO.
//   FIFO_DEPTH      : default entry count the lane passes as DEPTH
//   LANE_DATA_WIDTH : default entry width
//   fifo_flags_t    : registered status flags (empty/full/almost)
//   flags_from_level: derives every flag from one occupancy value

package v_lane_sync_fifo_pkg;

    localparam int FIFO_DEPTH      = 512;
    localparam int LANE_DATA_WIDTH = 32;
    localparam int ALMOST_OFFSET   = 8;

    typedef struct packed {
        logic empty;
        logic full;
        logic almostempty;
        logic almostfull;
    } fifo_flags_t;

    // All flags come from the same occupancy so they can never disagree
    // with each other or with level_o.
    function automatic fifo_flags_t flags_from_level(
        input int level,
        input int depth,
        input int ae_offset,
        input int af_offset
    );
        fifo_flags_t f;
        f.empty       = (level == 0);
        f.full        = (level == depth);
        f.almostempty = (level <= ae_offset);
        f.almostfull  = (level >= depth - af_offset);
        return f;
    endfunction

endpackage

// File: rtl/v_lane_fifo_mem.sv
// v_lane_fifo_mem
//   DEPTH x DATA_WIDTH storage, one write port and one read port.
//   SYNC_READ = 1: registered read (rdata loads mem[raddr] when re), the
//                  output register is cleared by reset. This form maps onto
//                  block RAM at larger depths and distributed RAM otherwise.
//   SYNC_READ = 0: asynchronous read (rdata = mem[raddr]); reset/re unused.
//   Ports: clk, reset (sync, active low), we/waddr/wdata, re/raddr, rdata.
//   Storage itself is never cleared.

module v_lane_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter bit SYNC_READ  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset on the array so it stays a plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (SYNC_READ) begin : g_sync
            always_ff @(posedge clk) begin
                if (!reset)  rdata <= '0;
                else if (re) rdata <= mem[raddr];
            end
        end else begin : g_async
            logic unused;
            assign unused = ^{reset, re};
            assign rdata  = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/v_lane_sync_fifo.sv
// v_lane_sync_fifo
//   Parametrised synchronous FIFO for the vector lane load and store paths.
//   Ports:
//     clk, reset (sync, active low), flush_i (sync clear, beats we/re)
//     we_i/wdata_i : write request and data
//     re_i/rdata_o : read request and data (registered or FWFT)
//     empty_o, full_o, almostempty_o, almostfull_o : registered flags
//     level_o      : occupancy 0..DEPTH
//     rdcount_o, wrcount_o : read / write pointers, wrap modulo DEPTH
//     rderr_o, wrerr_o     : one-cycle pulses after a rejected request
//   All status outputs are registers; we_i/re_i only reach them through
//   the next-state logic.

module v_lane_sync_fifo
    import v_lane_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = LANE_DATA_WIDTH,
    parameter int DEPTH               = FIFO_DEPTH,
    parameter int ALMOST_EMPTY_OFFSET = ALMOST_OFFSET,
    parameter int ALMOST_FULL_OFFSET  = ALMOST_OFFSET,
    parameter bit FWFT                = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     we_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic                     re_i,
    output logic [DATA_WIDTH-1:0]    rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almostempty_o,
    output logic                     almostfull_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH)-1:0] rdcount_o,
    output logic [$clog2(DEPTH)-1:0] wrcount_o,
    output logic                     rderr_o,
    output logic                     wrerr_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    fifo_flags_t   flags;
    fifo_flags_t   flags_next;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_rej;
    logic          rd_rej;

    // Acceptance uses the registered flags, never the current requests'
    // effect, so a read on empty is rejected even if a write lands now.
    always_comb begin
        wr_acc = we_i && !flags.full  && !flush_i;
        rd_acc = re_i && !flags.empty && !flush_i;
        wr_rej = we_i &&  flags.full  && !flush_i;
        rd_rej = re_i &&  flags.empty && !flush_i;

        level_next = level;
        if (flush_i)
            level_next = '0;
        else if (wr_acc && !rd_acc)
            level_next = level + (AW+1)'(1);
        else if (rd_acc && !wr_acc)
            level_next = level - (AW+1)'(1);

        // Flags are registered from the next level so they move with level_o.
        flags_next = flags_from_level(int'(level_next), DEPTH,
                                      ALMOST_EMPTY_OFFSET, ALMOST_FULL_OFFSET);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            flags   <= '{empty: 1'b1, full: 1'b0, almostempty: 1'b1, almostfull: 1'b0};
            rderr_o <= 1'b0;
            wrerr_o <= 1'b0;
        end else begin
            level   <= level_next;
            flags   <= flags_next;
            rderr_o <= rd_rej;
            wrerr_o <= wr_rej;
            if (flush_i) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + AW'(1);
                if (rd_acc) rptr <= rptr + AW'(1);
            end
        end
    end

    // Standard mode: registered read port loads the head on a pop and holds
    // otherwise (including across flush). FWFT mode: the head is always
    // visible combinationally from rptr.
    v_lane_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .SYNC_READ  (!FWFT)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc && reset),
        .waddr (wptr),
        .wdata (wdata_i),
        .re    (rd_acc && reset),
        .raddr (rptr),
        .rdata (rdata_o)
    );

    assign empty_o       = flags.empty;
    assign full_o        = flags.full;
    assign almostempty_o = flags.almostempty;
    assign almostfull_o  = flags.almostfull;
    assign level_o       = level;
    assign rdcount_o     = rptr;
    assign wrcount_o     = wptr;

endmodule

// File: tb/tb_v_lane_sync_fifo.sv
// tb_v_lane_sync_fifo
//   Directed bench: instance a is the default lane FIFO (512 x 32, offsets
//   8, standard read); instance b is FWFT, DEPTH 16, offsets 2.

module tb_v_lane_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // instance a
    logic        a_reset = 1'b0, a_flush = 1'b0, a_we = 1'b0, a_re = 1'b0;
    logic [31:0] a_wdata = '0, a_rdata;
    logic        a_empty, a_full, a_aempty, a_afull, a_rderr, a_wrerr;
    logic [9:0]  a_level;
    logic [8:0]  a_rdc, a_wrc;

    v_lane_sync_fifo #(
        .DATA_WIDTH(32), .DEPTH(512), .ALMOST_EMPTY_OFFSET(8),
        .ALMOST_FULL_OFFSET(8), .FWFT(1'b0)
    ) dut_a (
        .clk(clk), .reset(a_reset), .flush_i(a_flush), .we_i(a_we),
        .wdata_i(a_wdata), .re_i(a_re), .rdata_o(a_rdata),
        .empty_o(a_empty), .full_o(a_full), .almostempty_o(a_aempty),
        .almostfull_o(a_afull), .level_o(a_level), .rdcount_o(a_rdc),
        .wrcount_o(a_wrc), .rderr_o(a_rderr), .wrerr_o(a_wrerr)
    );

    // instance b
    logic        b_reset = 1'b0, b_flush = 1'b0, b_we = 1'b0, b_re = 1'b0;
    logic [31:0] b_wdata = '0, b_rdata;
    logic        b_empty, b_full, b_aempty, b_afull, b_rderr, b_wrerr;
    logic [4:0]  b_level;
    logic [3:0]  b_rdc, b_wrc;

    v_lane_sync_fifo #(
        .DATA_WIDTH(32), .DEPTH(16), .ALMOST_EMPTY_OFFSET(2),
        .ALMOST_FULL_OFFSET(2), .FWFT(1'b1)
    ) dut_b (
        .clk(clk), .reset(b_reset), .flush_i(b_flush), .we_i(b_we),
        .wdata_i(b_wdata), .re_i(b_re), .rdata_o(b_rdata),
        .empty_o(b_empty), .full_o(b_full), .almostempty_o(b_aempty),
        .almostfull_o(b_afull), .level_o(b_level), .rdcount_o(b_rdc),
        .wrcount_o(b_wrc), .rderr_o(b_rderr), .wrerr_o(b_wrerr)
    );

    initial begin
        tick(); tick();
        a_reset = 1'b1;
        b_reset = 1'b1;

        // reset state, instance a
        chk("a_rst_rdata",  a_rdata, 0);
        chk("a_rst_level",  32'(a_level), 0);
        chk("a_rst_empty",  32'(a_empty), 1);
        chk("a_rst_aempty", 32'(a_aempty), 1);
        chk("a_rst_full",   32'(a_full), 0);
        chk("a_rst_afull",  32'(a_afull), 0);
        chk("a_rst_cnts",   32'({a_rdc, a_wrc}), 0);
        chk("a_rst_errs",   32'({a_rderr, a_wrerr}), 0);

        // fill 1..512
        for (int i = 1; i <= 512; i++) begin
            a_we = 1'b1; a_wdata = i;
            tick();
            if (i == 1)   chk("a_fill1_empty", 32'(a_empty), 0);
            if (i == 8)   chk("a_fill8_aempty", 32'(a_aempty), 1);
            if (i == 9)   chk("a_fill9_aempty", 32'(a_aempty), 0);
            if (i == 503) chk("a_fill503_afull", 32'(a_afull), 0);
            if (i == 504) chk("a_fill504_afull", 32'(a_afull), 1);
            if (i == 511) chk("a_fill511_full", 32'(a_full), 0);
        end
        a_we = 1'b0;
        chk("a_full",      32'(a_full), 1);
        chk("a_full_lvl",  32'(a_level), 512);
        chk("a_full_wrc",  32'(a_wrc), 0);

        // write while full
        a_we = 1'b1; a_wdata = 32'hDEAD;
        tick();
        a_we = 1'b0;
        chk("a_wrerr_pulse", 32'(a_wrerr), 1);
        chk("a_wrerr_lvl",   32'(a_level), 512);
        tick();
        chk("a_wrerr_clear", 32'(a_wrerr), 0);

        // drain, in order, 1-cycle latency
        for (int i = 1; i <= 512; i++) begin
            a_re = 1'b1;
            tick();
            chk("a_rd_data", a_rdata, i);
            if (i == 503) chk("a_rd503_aempty", 32'(a_aempty), 0);
            if (i == 504) chk("a_rd504_aempty", 32'(a_aempty), 1);
            if (i == 511) chk("a_rd511_empty", 32'(a_empty), 0);
        end
        a_re = 1'b0;
        chk("a_drain_empty", 32'(a_empty), 1);
        chk("a_drain_lvl",   32'(a_level), 0);
        chk("a_drain_rdc",   32'(a_rdc), 0);

        // read on empty with write
        a_re = 1'b1; a_we = 1'b1; a_wdata = 32'hA5A5;
        tick();
        a_re = 1'b0; a_we = 1'b0;
        chk("a_rderr_pulse", 32'(a_rderr), 1);
        chk("a_rderr_lvl",   32'(a_level), 1);
        chk("a_rderr_hold",  a_rdata, 512);
        a_re = 1'b1;
        tick();
        a_re = 1'b0;
        chk("a_rd_a5a5",     a_rdata, 32'hA5A5);
        chk("a_rderr_clear", 32'(a_rderr), 0);
        chk("a_rd_a5_lvl",   32'(a_level), 0);

        // flush at level 100
        for (int i = 0; i < 100; i++) begin
            a_we = 1'b1; a_wdata = 32'h100 + i;
            tick();
        end
        chk("a_lvl100", 32'(a_level), 100);
        a_we = 1'b1; a_re = 1'b1; a_flush = 1'b1; a_wdata = 32'hBAD;
        tick();
        a_we = 1'b0; a_re = 1'b0; a_flush = 1'b0;
        chk("a_fl_lvl",   32'(a_level), 0);
        chk("a_fl_empty", 32'(a_empty), 1);
        chk("a_fl_cnts",  32'({a_rdc, a_wrc}), 0);
        chk("a_fl_errs",  32'({a_rderr, a_wrerr}), 0);
        chk("a_fl_rdata", a_rdata, 32'hA5A5);
        a_we = 1'b1; a_wdata = 32'h77;
        tick();
        a_we = 1'b0; a_re = 1'b1;
        tick();
        a_re = 1'b0;
        chk("a_post_fl_rd", a_rdata, 32'h77);

        // reset mid-stream at level 300
        for (int i = 0; i < 300; i++) begin
            a_we = 1'b1; a_wdata = 32'h1000 + i;
            tick();
        end
        chk("a_lvl300", 32'(a_level), 300);
        a_reset = 1'b0; a_wdata = 32'hBAD;
        tick();
        a_reset = 1'b1; a_we = 1'b0;
        chk("a_mrst_rdata", a_rdata, 0);
        chk("a_mrst_lvl",   32'(a_level), 0);
        chk("a_mrst_flags", 32'({a_empty, a_aempty, a_full, a_afull}), 32'b1100);
        chk("a_mrst_cnts",  32'({a_rdc, a_wrc}), 0);
        chk("a_mrst_errs",  32'({a_rderr, a_wrerr}), 0);
        a_we = 1'b1; a_wdata = 32'hBEEF;
        tick();
        a_we = 1'b0; a_re = 1'b1;
        tick();
        a_re = 1'b0;
        chk("a_mrst_new", a_rdata, 32'hBEEF);
        chk("a_mrst_new_lvl", 32'(a_level), 0);

        // instance b, FWFT
        chk("b_rst_flags", 32'({b_empty, b_aempty, b_full, b_afull}), 32'b1100);
        chk("b_rst_lvl",   32'(b_level), 0);
        b_we = 1'b1; b_wdata = 32'h11;
        tick();
        b_we = 1'b0;
        chk("b_w11_empty",  32'(b_empty), 0);
        chk("b_w11_rdata",  b_rdata, 32'h11);
        chk("b_w11_aempty", 32'(b_aempty), 1);
        b_we = 1'b1; b_re = 1'b1; b_wdata = 32'h22;
        tick();
        b_we = 1'b0; b_re = 1'b0;
        chk("b_rw_lvl",   32'(b_level), 1);
        chk("b_rw_rdata", b_rdata, 32'h22);
        chk("b_rw_errs",  32'({b_rderr, b_wrerr}), 0);
        chk("b_rw_cnts",  32'({b_rdc, b_wrc}), 32'h12);
        b_we = 1'b1; b_wdata = 32'h33;
        tick();
        chk("b_l2_aempty", 32'(b_aempty), 1);
        b_wdata = 32'h44;
        tick();
        chk("b_l3_aempty", 32'(b_aempty), 0);
        chk("b_l3_rdata",  b_rdata, 32'h22);
        for (int j = 4; j <= 16; j++) begin
            b_wdata = 32'h40 + j;
            tick();
            if (j == 13) chk("b_l13_afull", 32'(b_afull), 0);
            if (j == 14) chk("b_l14_afull", 32'(b_afull), 1);
            if (j == 15) chk("b_l15_full",  32'(b_full), 0);
            if (j == 16) chk("b_l16_full",  32'(b_full), 1);
        end
        b_wdata = 32'hDEAD;
        tick();
        b_we = 1'b0;
        chk("b_wrerr", 32'(b_wrerr), 1);
        chk("b_wrerr_lvl", 32'(b_level), 16);
        b_re = 1'b1;
        tick();
        b_re = 1'b0;
        chk("b_pop_rdata", b_rdata, 32'h33);
        chk("b_pop_lvl",   32'(b_level), 15);
        chk("b_pop_flags", 32'({b_full, b_afull}), 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
